// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package hazard_stall_ctrl_pkg;

    // Default number of cycles a DIV/DIVU occupies EXE.
    localparam int DIV_LATENCY_DEF = 32;
    localparam int REG_W           = 5;

    // Register-file / HI / LO write type carried with each instruction.
    typedef struct packed {
        logic RFWr;
        logic HIWr;
        logic LOWr;
    } RegsWrType;

    // Divider occupancy state.
    typedef enum logic {
        S_RUN = 1'b0,
        S_DIV = 1'b1
    } HazState_t;

    // Pipeline register write enables, PC first.
    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_exe;
        logic exe_mem;
        logic mem_wb;
    } stage_wr_t;

    // Pipeline register bubble inserts.
    typedef struct packed {
        logic if_id;
        logic id_exe;
        logic exe_mem;
        logic mem_wb;
    } stage_flush_t;

    // True when an ID source operand is really read and names the given register.
    function automatic logic src_hits(input logic used,
                                      input logic [REG_W-1:0] src,
                                      input logic [REG_W-1:0] dst);
        return used && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side view of the stall/flush controller: hazard inputs and register controls.
interface hazard_stall_ctrl_if
    import hazard_stall_ctrl_pkg::*;
();

    logic [REG_W-1:0] ID_rs;
    logic [REG_W-1:0] ID_rt;
    logic             ID_UseRs;
    logic             ID_UseRt;
    RegsWrType        EXE_RegsWrType;
    logic [REG_W-1:0] EXE_Dst;
    logic             EXE_MemRead;
    logic             EXE_DivStart;
    logic             MEM_DReq;
    logic             DMem_Ready;
    logic             Exc_Flush;
    logic             Branch_Taken;

    logic             PC_Wr;
    logic             IF_ID_Wr;
    logic             ID_EXE_Wr;
    logic             EXE_MEM_Wr;
    logic             MEM_WB_Wr;
    logic             IF_ID_Flush;
    logic             ID_EXE_Flush;
    logic             EXE_MEM_Flush;
    logic             MEM_WB_Flush;
    logic             Div_Busy;
    logic             Div_Done;

    // Pipeline datapath side: presents hazard information, obeys the controls.
    modport master (
        output ID_rs, ID_rt, ID_UseRs, ID_UseRt, EXE_RegsWrType, EXE_Dst,
               EXE_MemRead, EXE_DivStart, MEM_DReq, DMem_Ready, Exc_Flush, Branch_Taken,
        input  PC_Wr, IF_ID_Wr, ID_EXE_Wr, EXE_MEM_Wr, MEM_WB_Wr,
               IF_ID_Flush, ID_EXE_Flush, EXE_MEM_Flush, MEM_WB_Flush, Div_Busy, Div_Done
    );

    // Controller side.
    modport slave (
        input  ID_rs, ID_rt, ID_UseRs, ID_UseRt, EXE_RegsWrType, EXE_Dst,
               EXE_MemRead, EXE_DivStart, MEM_DReq, DMem_Ready, Exc_Flush, Branch_Taken,
        output PC_Wr, IF_ID_Wr, ID_EXE_Wr, EXE_MEM_Wr, MEM_WB_Wr,
               IF_ID_Flush, ID_EXE_Flush, EXE_MEM_Flush, MEM_WB_Flush, Div_Busy, Div_Done
    );

endinterface

// File: rtl/hazard_stall_ctrl_div_occupancy_cnt.sv
// Tracks how long a divide has occupied EXE and signals when its result is valid.
// The count runs regardless of memory freeze; a completion that lands inside a
// freeze is remembered and released on the first unfrozen cycle.
module div_occupancy_cnt
    import hazard_stall_ctrl_pkg::*;
#(
    parameter  int DIV_LATENCY = DIV_LATENCY_DEF,
    localparam int CNT_W       = $clog2(DIV_LATENCY + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic div_start,   // DIV/DIVU present in EXE
    input  logic abort,       // exception flush kills the divide
    input  logic freeze,      // data-memory wait holds the whole pipeline
    output logic busy,
    output logic done
);

    HazState_t        st;
    logic [CNT_W-1:0] div_cnt;
    logic             done_pend;

    // Result is valid once the count is exhausted (now or earlier during a freeze)
    // and the pipeline is free to move the divide out of EXE.
    assign busy = (st == S_DIV);
    assign done = busy && !abort && !freeze && ((div_cnt == '0) || done_pend);

    // Occupancy state machine, counter and pending-completion flag.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= S_RUN;
            div_cnt   <= '0;
            done_pend <= 1'b0;
        end else if (abort) begin
            st        <= S_RUN;
            div_cnt   <= '0;
            done_pend <= 1'b0;
        end else begin
            case (st)
                S_RUN: begin
                    if (div_start) begin
                        st        <= S_DIV;
                        div_cnt   <= CNT_W'(DIV_LATENCY - 1);
                        done_pend <= 1'b0;
                    end
                end
                S_DIV: begin
                    if (done) begin
                        st        <= S_RUN;
                        div_cnt   <= '0;
                        done_pend <= 1'b0;
                    end else begin
                        if (div_cnt != '0) begin
                            div_cnt <= div_cnt - CNT_W'(1);
                        end
                        if ((div_cnt == '0) && freeze) begin
                            done_pend <= 1'b1;
                        end
                    end
                end
                default: begin
                    st <= S_RUN;
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: resolves load-use, divide occupancy, data-memory
// wait, exception and taken-branch hazards into per-stage write enables and flushes.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int DIV_LATENCY = DIV_LATENCY_DEF
) (
    input logic              clk,
    input logic              rst,
    hazard_stall_ctrl_if.slave bus
);

    logic         div_busy;
    logic         div_done;
    logic         mem_wait;
    logic         div_stall;
    logic         load_use;
    stage_wr_t    wr;
    stage_flush_t fl;

    div_occupancy_cnt #(
        .DIV_LATENCY (DIV_LATENCY)
    ) u_div_cnt (
        .clk       (clk),
        .rst       (rst),
        .div_start (bus.EXE_DivStart),
        .abort     (bus.Exc_Flush),
        .freeze    (mem_wait),
        .busy      (div_busy),
        .done      (div_done)
    );

    // Hazard conditions seen this cycle.
    assign mem_wait  = bus.MEM_DReq && !bus.DMem_Ready;
    assign div_stall = div_busy && !div_done;
    assign load_use  = bus.EXE_MemRead && bus.EXE_RegsWrType.RFWr && (bus.EXE_Dst != '0) &&
                       (src_hits(bus.ID_UseRs, bus.ID_rs, bus.EXE_Dst) ||
                        src_hits(bus.ID_UseRt, bus.ID_rt, bus.EXE_Dst));

    // Priority encode the hazards into stage controls; a taken branch only
    // flushes IF/ID when nothing is stalling, otherwise ID re-presents it later.
    always_comb begin
        // NOTE: every output gets a default before the priority chain so no
        // path through the block leaves a value held, which would infer a latch.
        wr = '{pc: 1'b1, if_id: 1'b1, id_exe: 1'b1, exe_mem: 1'b1, mem_wb: 1'b1};
        fl = '0;
        if (rst) begin
            wr = '0;
            fl = '1;
        end else if (bus.Exc_Flush) begin
            fl.if_id   = 1'b1;
            fl.id_exe  = 1'b1;
            fl.exe_mem = 1'b1;
        end else if (mem_wait) begin
            wr = '0;
        end else if (div_stall) begin
            wr.pc      = 1'b0;
            wr.if_id   = 1'b0;
            wr.id_exe  = 1'b0;
            fl.exe_mem = 1'b1;
        end else if (load_use) begin
            wr.pc      = 1'b0;
            wr.if_id   = 1'b0;
            fl.id_exe  = 1'b1;
        end else if (bus.Branch_Taken) begin
            fl.if_id   = 1'b1;
        end
    end

    assign bus.PC_Wr         = wr.pc;
    assign bus.IF_ID_Wr      = wr.if_id;
    assign bus.ID_EXE_Wr     = wr.id_exe;
    assign bus.EXE_MEM_Wr    = wr.exe_mem;
    assign bus.MEM_WB_Wr     = wr.mem_wb;
    assign bus.IF_ID_Flush   = fl.if_id;
    assign bus.ID_EXE_Flush  = fl.id_exe;
    assign bus.EXE_MEM_Flush = fl.exe_mem;
    assign bus.MEM_WB_Flush  = fl.mem_wb;
    assign bus.Div_Busy      = div_busy && !rst;
    assign bus.Div_Done      = div_done && !rst;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with a cycle-level reference model.
module tb_hazard_stall_ctrl;
    import hazard_stall_ctrl_pkg::*;

    localparam int L = 4;

    // Output vector: {PC,IF_ID,ID_EXE,EXE_MEM,MEM_WB}_Wr, {IF_ID,ID_EXE,EXE_MEM,MEM_WB}_Flush, Busy, Done
    localparam logic [10:0] V_RESET    = 11'b00000_1111_00;
    localparam logic [10:0] V_RUN      = 11'b11111_0000_00;
    localparam logic [10:0] V_LU       = 11'b00111_0100_00;
    localparam logic [10:0] V_BR       = 11'b11111_1000_00;
    localparam logic [10:0] V_DIVST    = 11'b00011_0010_10;
    localparam logic [10:0] V_DIVDONE  = 11'b11111_0000_11;
    localparam logic [10:0] V_FRZ      = 11'b00000_0000_00;
    localparam logic [10:0] V_FRZ_DIV  = 11'b00000_0000_10;
    localparam logic [10:0] V_EXC      = 11'b11111_1110_00;
    localparam logic [10:0] V_EXC_DIV  = 11'b11111_1110_10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_stall_ctrl_if bus ();

    hazard_stall_ctrl #(.DIV_LATENCY(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    logic [10:0] act_vec;
    assign act_vec = {bus.PC_Wr, bus.IF_ID_Wr, bus.ID_EXE_Wr, bus.EXE_MEM_Wr, bus.MEM_WB_Wr,
                      bus.IF_ID_Flush, bus.ID_EXE_Flush, bus.EXE_MEM_Flush, bus.MEM_WB_Flush,
                      bus.Div_Busy, bus.Div_Done};

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Divide tracked as "cycles spent occupying EXE so far"; result is ready once
    // that reaches the latency, and leaves EXE on the first cycle not frozen.
    bit          m_busy    = 1'b0;
    int          m_elapsed = 0;
    logic        m_done;
    logic [10:0] exp_vec;

    always_comb begin
        logic wait_m, lu_m, rs_hit, rt_hit;
        wait_m = bus.MEM_DReq && !bus.DMem_Ready;
        rs_hit = bus.ID_UseRs && (bus.ID_rs == bus.EXE_Dst);
        rt_hit = bus.ID_UseRt && (bus.ID_rt == bus.EXE_Dst);
        lu_m   = bus.EXE_MemRead && bus.EXE_RegsWrType.RFWr && (bus.EXE_Dst != 5'd0) && (rs_hit || rt_hit);
        m_done = !rst && m_busy && (m_elapsed >= L) && !bus.Exc_Flush && !wait_m;
        if (rst)                        exp_vec = V_RESET;
        else if (bus.Exc_Flush)         exp_vec = V_EXC;
        else if (wait_m)                exp_vec = V_FRZ;
        else if (m_busy && !m_done)     exp_vec = V_DIVST;
        else if (lu_m)                  exp_vec = V_LU;
        else if (bus.Branch_Taken)      exp_vec = V_BR;
        else                            exp_vec = V_RUN;
        exp_vec[1] = m_busy && !rst;
        exp_vec[0] = m_done;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_busy    <= 1'b0;
            m_elapsed <= 0;
        end else if (bus.Exc_Flush) begin
            m_busy <= 1'b0;
        end else if (!m_busy) begin
            if (bus.EXE_DivStart) begin
                m_busy    <= 1'b1;
                m_elapsed <= 1;
            end
        end else if (m_done) begin
            m_busy <= 1'b0;
        end else begin
            m_elapsed <= m_elapsed + 1;
        end
    end

    // Every-cycle compare of DUT against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) check("cycle", act_vec, exp_vec);
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        bus.ID_rs          = 5'd0;
        bus.ID_rt          = 5'd0;
        bus.ID_UseRs       = 1'b0;
        bus.ID_UseRt       = 1'b0;
        bus.EXE_RegsWrType = '0;
        bus.EXE_Dst        = 5'd0;
        bus.EXE_MemRead    = 1'b0;
        bus.EXE_DivStart   = 1'b0;
        bus.MEM_DReq       = 1'b0;
        bus.DMem_Ready     = 1'b0;
        bus.Exc_Flush      = 1'b0;
        bus.Branch_Taken   = 1'b0;
    endtask

    task automatic load_in_exe(input logic [4:0] dst, input logic rfwr);
        bus.EXE_MemRead    = 1'b1;
        bus.EXE_Dst        = dst;
        bus.EXE_RegsWrType = '{RFWr: rfwr, HIWr: 1'b0, LOWr: 1'b0};
    endtask

    task automatic id_reads(input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt);
        bus.ID_rs    = rs;
        bus.ID_UseRs = urs;
        bus.ID_rt    = rt;
        bus.ID_UseRt = urt;
    endtask

    // Pin DUT and model to a hand-computed vector this cycle, then advance.
    task automatic step(input string name, input logic [10:0] exp);
        @(negedge clk);
        check({name, "_dut"}, act_vec, exp);
        check({name, "_model"}, exp_vec, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        cmp_en = 1'b1;
        step("reset", V_RESET);
        rst = 1'b0;
        step("idle", V_RUN);

        // Load-use on rs: one bubble, then consumer proceeds.
        load_in_exe(5'd2, 1'b1); id_reads(5'd2, 1'b1, 5'd4, 1'b1);
        step("lu_rs", V_LU);
        idle(); bus.EXE_Dst = 5'd3; bus.EXE_RegsWrType = '{RFWr: 1'b1, HIWr: 1'b0, LOWr: 1'b0};
        id_reads(5'd7, 1'b1, 5'd8, 1'b1);
        step("lu_after", V_RUN);

        // Load to $0 never stalls; unused rt never stalls; used rt does.
        idle(); load_in_exe(5'd0, 1'b1); id_reads(5'd0, 1'b1, 5'd0, 1'b1);
        step("lw_r0", V_RUN);
        idle(); load_in_exe(5'd2, 1'b1); id_reads(5'd5, 1'b1, 5'd2, 1'b0);
        step("lw_rt_unused", V_RUN);
        id_reads(5'd5, 1'b1, 5'd2, 1'b1);
        step("lu_rt", V_LU);
        load_in_exe(5'd2, 1'b0);
        step("lw_no_rfwr", V_RUN);

        // Branch alone flushes IF/ID; under load-use it is ignored.
        idle(); bus.Branch_Taken = 1'b1;
        step("branch", V_BR);
        load_in_exe(5'd9, 1'b1); id_reads(5'd9, 1'b1, 5'd0, 1'b0);
        step("branch_lu", V_LU);

        // Divide, held DivStart must not restart it; branch ignored under stall.
        idle(); bus.EXE_DivStart = 1'b1;
        step("div_entry", V_RUN);
        step("div_st1", V_DIVST);
        bus.Branch_Taken = 1'b1;
        step("div_st2_br", V_DIVST);
        bus.Branch_Taken = 1'b0;
        step("div_st3", V_DIVST);
        bus.EXE_DivStart = 1'b0;
        step("div_done", V_DIVDONE);
        step("div_after", V_RUN);

        // Memory wait across divide completion: done held until release.
        bus.EXE_DivStart = 1'b1;
        step("dw_entry", V_RUN);
        bus.EXE_DivStart = 1'b0;
        step("dw_st1", V_DIVST);
        bus.MEM_DReq = 1'b1; bus.DMem_Ready = 1'b0;
        step("dw_frz1", V_FRZ_DIV);
        step("dw_frz2", V_FRZ_DIV);
        step("dw_frz3", V_FRZ_DIV);
        bus.DMem_Ready = 1'b1;
        step("dw_release", V_DIVDONE);
        idle();
        step("dw_after", V_RUN);

        // Memory wait with no divide freezes everything, overriding load-use.
        bus.MEM_DReq = 1'b1; load_in_exe(5'd4, 1'b1); id_reads(5'd4, 1'b1, 5'd0, 1'b0);
        step("frz_lu", V_FRZ);
        idle();

        // Exception mid-divide (counter at 2) aborts it.
        bus.EXE_DivStart = 1'b1;
        step("ex_entry", V_RUN);
        bus.EXE_DivStart = 1'b0;
        step("ex_st1", V_DIVST);
        bus.Exc_Flush = 1'b1;
        step("ex_flush", V_EXC_DIV);
        bus.Exc_Flush = 1'b0;
        step("ex_after", V_RUN);

        // Exception beats memory wait and blocks a divide start.
        bus.Exc_Flush = 1'b1; bus.MEM_DReq = 1'b1; bus.EXE_DivStart = 1'b1;
        step("ex_frz_start", V_EXC);
        idle();
        step("ex_no_div", V_RUN);

        // Reset mid-divide during memory wait, then a clean full divide.
        bus.EXE_DivStart = 1'b1;
        step("rs_entry", V_RUN);
        bus.EXE_DivStart = 1'b0;
        step("rs_st1", V_DIVST);
        bus.MEM_DReq = 1'b1;
        step("rs_frz", V_FRZ_DIV);
        rst = 1'b1;
        step("rs_reset", V_RESET);
        rst = 1'b0; idle();
        step("rs_after", V_RUN);
        bus.EXE_DivStart = 1'b1;
        step("rs_div_entry", V_RUN);
        bus.EXE_DivStart = 1'b0;
        for (int i = 0; i < L - 1; i++) step("rs_div_st", V_DIVST);
        step("rs_div_done", V_DIVDONE);
        step("rs_div_after", V_RUN);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
